mips_alu_mc: RTL and testbench

//   Parametrised multi-cycle ALU for the MIPS datapath.
//   - Single-cycle logic/arithmetic ops: OR, AND, XOR, ADD, NOR, NAND, SLT, SUB.
//   - Iterative MULT/MULTU/DIV/DIVU, writing HI/LO.
//   - Valid/ready handshake on input and output, so control can stall on long ops.

---
 rtl/mips_alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_mips_alu_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative MULT/MULTU/DIV/DIVU
// sharing one 2*WIDTH shift register, with valid/ready handshakes on both sides.
module mips_alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_a, r_neg_b, r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result, r_hi, r_lo;
  logic               r_zero, r_ovf, r_dbz;

  logic               w_accept, w_is_long, w_last;
  logic [WIDTH-1:0]   w_sum, w_diff, w_alu_res;
  logic               w_alu_ovf;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_madd, w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_dsub;
  logic [2*WIDTH-1:0] w_p_next, w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix, w_fin_hi, w_fin_lo;

  assign w_accept  = in_valid & in_ready;
  assign w_is_long = op[3] & ~op[2];
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_is_long ? S_EXEC : S_DONE;
      S_EXEC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = ~rst;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle operations
  always_comb begin
    w_sum     = a + b;
    w_diff    = a - b;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (op)
      OP_OR:   w_alu_res = a | b;
      OP_AND:  w_alu_res = a & b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOR:  w_alu_res = ~(a | b);
      OP_NAND: w_alu_res = ~(a & b);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: w_alu_res = '0;
    endcase
  end

  // Operand magnitudes; signed ops are op 8 and 10 (op[0] clear)
  always_comb begin
    w_neg_a = ~op[0] & a[WIDTH-1];
    w_neg_b = ~op[0] & b[WIDTH-1];
    w_mag_a = w_neg_a ? (-a) : a;
    w_mag_b = w_neg_b ? (-b) : b;
  end

  // One iteration: shift-add multiply or restoring divide on r_p = {upper, lower}
  always_comb begin
    w_madd   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
    w_shift  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opnd});
    w_dsub   = w_shift[WIDTH-1:0] - r_opnd;
    if (r_div) w_p_next = {(w_ge ? w_dsub : w_shift[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};
    else       w_p_next = {w_madd, r_p[WIDTH-1:1]};
    w_prod_fix = (r_neg_a ^ r_neg_b) ? (-w_p_next) : w_p_next;
    w_q_fix    = (r_neg_a ^ r_neg_b) ? (-w_p_next[WIDTH-1:0]) : w_p_next[WIDTH-1:0];
    w_r_fix    = r_neg_a ? (-w_p_next[2*WIDTH-1:WIDTH]) : w_p_next[2*WIDTH-1:WIDTH];
    if (r_div) begin
      w_fin_hi = w_r_fix;
      w_fin_lo = (r_opnd == '0) ? '1 : w_q_fix;
    end else begin
      w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p      <= '0;
      r_opnd   <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      if (w_is_long) begin
        r_p     <= {{WIDTH{1'b0}}, w_mag_a};
        r_opnd  <= w_mag_b;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_div   <= op[1];
        r_cnt   <= '0;
      end else begin
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
        r_ovf    <= w_alu_ovf;
        r_dbz    <= 1'b0;
      end
    end else if (r_state == S_EXEC) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi     <= w_fin_hi;
        r_lo     <= w_fin_lo;
        r_result <= w_fin_lo;
        r_zero   <= (w_fin_lo == '0);
        r_ovf    <= 1'b0;
        r_dbz    <= r_div && (r_opnd == '0);
      end
    end
  end

  assign result = r_result;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign zero   = r_zero;
  assign ovf    = r_ovf;
  assign dbz    = r_dbz;

endmodule

// File: tb/tb_mips_alu_mc.sv
// Randomised bench for mips_alu_mc against an arithmetic reference model.
module tb_mips_alu_mc;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, ovf, dbz;
  logic [W-1:0] result, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] exp_res = '0, exp_hi = '0, exp_lo = '0;
  logic         exp_ovf = 1'b0, exp_dbz = 1'b0;
  logic         mon_en = 1'b0;

  mips_alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .hi(hi), .lo(lo), .zero(zero), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions of each op
  task automatic model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic [W-1:0] hi_in, input logic [W-1:0] lo_in,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic [W-1:0] l,
                       output logic ov, output logic dz);
    longint sa, sb, s, q, rm;
    logic [63:0] p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    h = hi_in; l = lo_in; ov = 1'b0; dz = 1'b0; r = '0;
    case (mop)
      4'd0: r = ma | mb;
      4'd1: r = ma & mb;
      4'd2: r = ma ^ mb;
      4'd3: begin s = sa + sb; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4: r = ~(ma | mb);
      4'd5: r = ~(ma & mb);
      4'd6: r = (sa < sb) ? W'(1) : W'(0);
      4'd7: begin s = sa - sb; r = W'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd8: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; r = l; end
      4'd9: begin p = {32'b0, ma} * {32'b0, mb}; h = p[63:32]; l = p[31:0]; r = l; end
      4'd10: begin
        if (mb == '0) begin l = '1; h = ma; dz = 1'b1; end
        else begin q = sa / sb; rm = sa % sb; l = W'(q); h = W'(rm); end
        r = l;
      end
      4'd11: begin
        if (mb == '0) begin l = '1; h = ma; dz = 1'b1; end
        else begin l = ma / mb; h = ma % mb; end
        r = l;
      end
      default: r = '0;
    endcase
  endtask

  // Every cycle a result is presented it must match the model and block new requests
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid) begin
      chk("mon_result", 64'(result), 64'(exp_res));
      chk("mon_hi",     64'(hi),     64'(exp_hi));
      chk("mon_lo",     64'(lo),     64'(exp_lo));
      chk("mon_zero",   64'(zero),   64'(exp_res == '0));
      chk("mon_ovf",    64'(ovf),    64'(exp_ovf));
      chk("mon_dbz",    64'(dbz),    64'(exp_dbz));
      chk("mon_in_ready_busy", 64'(in_ready), 64'(0));
    end
  end

  task automatic do_op(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input int hold);
    int lat, exp_lat;
    logic [W-1:0] r, h, l;
    logic ov, dz;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
    chk("wait_in_ready", 64'(in_ready), 64'(1));
    model(op_i, a_i, b_i, m_hi, m_lo, r, h, l, ov, dz);
    exp_res = r; exp_hi = h; exp_lo = l; exp_ovf = ov; exp_dbz = dz;
    m_hi = h; m_lo = l;
    exp_lat = (op_i inside {4'd8, 4'd9, 4'd10, 4'd11}) ? int'(W) + 1 : 1;
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Junk on the inputs while busy must be ignored
    op = 4'($urandom); a = $urandom; b = $urandom; in_valid = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    repeat (hold) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drops", 64'(out_valid), 64'(0));
    chk("ready_back",  64'(in_ready),  64'(1));
    chk("result_held", 64'(result),    64'(exp_res));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] r, h, l;
    logic ov, dz;

    // Global time limit
    fork
      begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result",    64'(result),    64'(0));
    chk("rst_hilo",      64'({hi, lo}),  64'(0));
    chk("rst_flags",     64'({zero, ovf, dbz}), 64'(0));
    mon_en = 1'b1;

    // Hand-computed anchors for the model itself
    model(4'd3, 32'h7FFF_FFFF, 32'h1, '0, '0, r, h, l, ov, dz);
    chk("pin_add", 64'({ov, r}), {31'b0, 1'b1, 32'h8000_0000});
    model(4'd8, 32'hFFFF_FFFE, 32'h3, '0, '0, r, h, l, ov, dz);
    chk("pin_mult", {h, l}, 64'hFFFF_FFFF_FFFF_FFFA);
    model(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, r, h, l, ov, dz);
    chk("pin_div_minneg", {31'b0, dz, h, l}, 64'h0000_0000_8000_0000);
    model(4'd11, 32'h9, 32'h0, '0, '0, r, h, l, ov, dz);
    chk("pin_divu_zero", {h, l}, 64'h0000_0009_FFFF_FFFF);

    // Directed cases with literal expectations on the DUT
    do_op(4'd3, 32'h7FFF_FFFF, 32'h1, 0);
    chk("add_ovf", 64'({result, ovf, zero}), {31'b0, 32'h8000_0000, 1'b1, 1'b0});
    do_op(4'd7, 32'h5, 32'h5, 0);
    chk("sub_zero", 64'({result, zero, ovf}), {31'b0, 32'h0, 1'b1, 1'b0});
    do_op(4'd6, 32'hFFFF_FFFF, 32'h1, 0);
    chk("slt_neg", 64'(result), 64'h1);
    do_op(4'd7, 32'hFFFF_FFFF, 32'h1, 0);
    chk("sub_vs_slt", 64'(result), 64'hFFFF_FFFE);
    do_op(4'd8, 32'hFFFF_FFFE, 32'h3, 0);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(4'd9, 32'hFFFF_FFFE, 32'h3, 0);
    chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    do_op(4'd10, 32'hFFFF_FFF9, 32'h2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(4'd11, 32'h9, 32'h0, 0);
    chk("divu_dbz", {31'b0, dbz, hi, lo}, 64'h0000_0001_0000_0009 << 32 | 64'hFFFF_FFFF);
    do_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_minneg_dut", {31'b0, dbz, hi, lo}, 64'h0000_0000_8000_0000);
    do_op(4'd13, 32'h1234, 32'h5678, 0);
    chk("reserved_keeps_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(4'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 5);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 250; i++) begin
      do_op(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3));
    end

    // Abort a DIVU at iteration 10 with reset
    @(negedge clk);
    op = 4'd11; a = 32'h1234_5678; b = 32'h77; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready",  64'(in_ready),  64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_hilo",      64'({hi, lo}),  64'(0));
    do_op(4'd3, 32'h10, 32'h20, 0);
    chk("add_after_abort", 64'({result, ovf}), 64'({32'h30, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
